// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the I/D-cache memory-port arbiter.
// MEM_ARB_RR_EN selects round-robin tie-breaking; see mem_arb_pick.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_I_FILL  = 2'd1,
        ARB_D_FILL  = 2'd2,
        ARB_D_WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Which side a non-idle state belongs to.
    function automatic arb_owner_t owner_of(arb_state_t s);
        return (s == ARB_I_FILL) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request signals and the shared memory port.
// The arbiter uses the slave modport; caches and memory model use master.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W_DEF
) ();

    // Handshake: a cache holds *_req (or d_wr) high until it is done; *_grant
    // follows one cycle later from IDLE. Fill owners release by dropping req,
    // a write owner is released by the one-cycle d_wr_done pulse. Dropping a
    // request before it is granted simply withdraws it.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr;
    logic [DATA_W-1:0] d_wdata;
    logic              i_grant;
    logic              d_grant;
    logic              i_data_valid;
    logic              d_data_valid;
    logic              d_wr_done;
    logic              memory_enable;
    logic              memory_write;
    logic [ADDR_W-1:0] memory_address;
    logic [DATA_W-1:0] memory_wdata;
    logic              memory_data_valid;

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wr, d_wdata, memory_data_valid,
        input  i_grant, d_grant, i_data_valid, d_data_valid, d_wr_done,
        input  memory_enable, memory_write, memory_address, memory_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata, memory_data_valid,
        output i_grant, d_grant, i_data_valid, d_data_valid, d_wr_done,
        output memory_enable, memory_write, memory_address, memory_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational choice of the next owner when the arbiter is idle.
// MEM_ARB_RR_EN: ties go to the side that did not own memory last.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_pend,
    input  logic       d_fill_pend,
    input  logic       d_wr_pend,
    input  arb_owner_t last_owner,
    output arb_state_t next_state
);

    logic       d_pend;
    arb_state_t d_state;

    assign d_pend  = d_fill_pend || d_wr_pend;
    // A fill outranks a write from the same side; the write stays pending.
    assign d_state = d_fill_pend ? ARB_D_FILL : ARB_D_WRITE;

    always_comb begin
        next_state = ARB_IDLE;
        if (i_pend && d_pend) begin
`ifdef MEM_ARB_RR_EN
            next_state = (last_owner == OWN_I) ? d_state : ARB_I_FILL;
`else
            next_state = d_state;
`endif
        end else if (i_pend) begin
            next_state = ARB_I_FILL;
        end else if (d_pend) begin
            next_state = d_state;
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the main-memory port between I-cache and D-cache controllers.
// MEM_ARB_RR_EN enables round-robin tie-breaking; default is fixed D priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output arb_state_t    state_dbg
);

    arb_state_t state;
    arb_state_t pick_next;
    arb_owner_t last_owner;

    mem_arb_pick u_pick (
        .i_pend      (bus.i_req),
        .d_fill_pend (bus.d_req),
        .d_wr_pend   (bus.d_wr),
        .last_owner  (last_owner),
        .next_state  (pick_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE:    state <= pick_next;
                ARB_I_FILL:  if (!bus.i_req) state <= ARB_IDLE;
                ARB_D_FILL:  if (!bus.d_req) state <= ARB_IDLE;
                ARB_D_WRITE: state <= ARB_IDLE;
                default:     state <= ARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_I;
        end else if (state == ARB_IDLE && pick_next != ARB_IDLE) begin
            last_owner <= owner_of(pick_next);
        end
    end
`else
    assign last_owner = OWN_I;
`endif

    assign state_dbg = state;

    // Everything decodes from the state register, so reset zeroes it at once.
    always_comb begin
        bus.i_grant        = (state == ARB_I_FILL);
        bus.d_grant        = (state == ARB_D_FILL) || (state == ARB_D_WRITE);
        bus.i_data_valid   = bus.memory_data_valid && (state == ARB_I_FILL);
        bus.d_data_valid   = bus.memory_data_valid && (state == ARB_D_FILL);
        bus.d_wr_done      = (state == ARB_D_WRITE);
        bus.memory_enable  = 1'b0;
        bus.memory_write   = 1'b0;
        bus.memory_address = '0;
        bus.memory_wdata   = '0;
        case (state)
            ARB_I_FILL: begin
                bus.memory_enable  = bus.i_req;
                bus.memory_address = bus.i_addr;
            end
            ARB_D_FILL: begin
                bus.memory_enable  = bus.d_req;
                bus.memory_address = bus.d_addr;
            end
            ARB_D_WRITE: begin
                bus.memory_enable  = 1'b1;
                bus.memory_write   = 1'b1;
                bus.memory_address = bus.d_addr;
                bus.memory_wdata   = bus.d_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against an
// owner-based reference model checked every cycle (honours MEM_ARB_RR_EN).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int M_NONE = 0;
    localparam int M_I    = 1;
    localparam int M_DF   = 2;
    localparam int M_DW   = 3;

    logic       clk;
    logic       rst_n;
    arb_state_t state_dbg;
    int         n_checks;
    int         n_pass;

    // reference model: who owns memory, and whether the last grant went to I
    int m_owner;
    bit m_i_last;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare against the model, then advance the model one cycle.
    always @(negedge clk) begin
        logic       e_en, e_wr;
        logic [15:0] e_addr, e_wdata;
        arb_state_t e_state;
        bit         wi, wd, win_i;
        if (!rst_n) begin
            m_owner  = M_NONE;
            m_i_last = 1'b1;
        end
        e_en = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_state = ARB_IDLE;
        if (m_owner == M_I)  begin e_en = bus.i_req; e_addr = bus.i_addr; e_state = ARB_I_FILL; end
        if (m_owner == M_DF) begin e_en = bus.d_req; e_addr = bus.d_addr; e_state = ARB_D_FILL; end
        if (m_owner == M_DW) begin
            e_en = 1; e_wr = 1; e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_state = ARB_D_WRITE;
        end
        chk("cyc_i_grant", bus.i_grant, m_owner == M_I);
        chk("cyc_d_grant", bus.d_grant, m_owner == M_DF || m_owner == M_DW);
        chk("cyc_i_dv", bus.i_data_valid, bus.memory_data_valid && m_owner == M_I);
        chk("cyc_d_dv", bus.d_data_valid, bus.memory_data_valid && m_owner == M_DF);
        chk("cyc_wr_done", bus.d_wr_done, m_owner == M_DW);
        chk("cyc_mem_en", bus.memory_enable, e_en);
        chk("cyc_mem_wr", bus.memory_write, e_wr);
        chk("cyc_mem_addr", bus.memory_address, e_addr);
        chk("cyc_mem_wdata", bus.memory_wdata, e_wdata);
        chk("cyc_state", state_dbg, e_state);
        if (rst_n) begin
            case (m_owner)
                M_I:  if (!bus.i_req) m_owner = M_NONE;
                M_DF: if (!bus.d_req) m_owner = M_NONE;
                M_DW: m_owner = M_NONE;
                default: begin
                    wi = bus.i_req;
                    wd = bus.d_req || bus.d_wr;
`ifdef MEM_ARB_RR_EN
                    win_i = wi && (!wd || !m_i_last);
`else
                    win_i = wi && !wd;
`endif
                    if (win_i) begin
                        m_owner = M_I; m_i_last = 1'b1;
                    end else if (wd) begin
                        m_owner = bus.d_req ? M_DF : M_DW; m_i_last = 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_addr = '0;
        bus.d_wr = 0; bus.d_wdata = '0; bus.memory_data_valid = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  i_dv_cnt, d_dv_cnt;
        bit  done_seen;
        n_checks = 0; n_pass = 0;
        m_owner = M_NONE; m_i_last = 1'b1;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_grant", bus.i_grant, 0);
        chk("rst_mem_en", bus.memory_enable, 0);
        chk("rst_state", state_dbg, ARB_IDLE);
        step();
        rst_n = 1'b1;

        // single I fill of 8 words
        step();
        bus.i_req = 1; bus.i_addr = 16'h0040;
        @(negedge clk); chk("t1_no_grant_yet", bus.i_grant, 0);
        step();
        @(negedge clk);
        chk("t1_i_grant", bus.i_grant, 1);
        chk("t1_addr", bus.memory_address, 16'h0040);
        chk("t1_en", bus.memory_enable, 1);
        i_dv_cnt = 0; d_dv_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            bus.memory_data_valid = 1; bus.i_addr = 16'h0040 + 16'(k);
            @(negedge clk);
            i_dv_cnt += int'(bus.i_data_valid);
            d_dv_cnt += int'(bus.d_data_valid);
        end
        chk("t1_i_dv_count", i_dv_cnt, 8);
        chk("t1_d_dv_count", d_dv_cnt, 0);
        step();
        bus.memory_data_valid = 0; bus.i_req = 0;
        @(negedge clk); chk("t1_drop_en", bus.memory_enable, 0);
        step();
        @(negedge clk); chk("t1_idle", state_dbg, ARB_IDLE);

        // simultaneous I and D requests
        step();
        bus.i_req = 1; bus.d_req = 1; bus.d_addr = 16'h2000;
        step();
        @(negedge clk);
        chk("t2_d_first", bus.d_grant, 1);
        chk("t2_i_wait", bus.i_grant, 0);
        chk("t2_addr", bus.memory_address, 16'h2000);
        step();
        step();
        bus.d_req = 0;
        @(negedge clk); chk("t2_d_hold", bus.d_grant, 1);
        step();
        bus.d_req = 1;
        @(negedge clk); chk("t2_bubble", {bus.i_grant, bus.d_grant}, 2'b00);
        step();
        @(negedge clk);
`ifdef MEM_ARB_RR_EN
        chk("t2_rr_tie_to_i", {bus.i_grant, bus.d_grant}, 2'b10);
`else
        chk("t2_fixed_tie_to_d", {bus.i_grant, bus.d_grant}, 2'b01);
        step();
        bus.d_req = 0;
        step();
        @(negedge clk); chk("t2_bubble2", {bus.i_grant, bus.d_grant}, 2'b00);
        step();
        @(negedge clk); chk("t2_i_after", bus.i_grant, 1);
`endif
        step();
        bus.i_req = 0; bus.d_req = 0;
        repeat (3) step();

        // write-through
        bus.d_wr = 1; bus.d_addr = 16'h1234; bus.d_wdata = 16'hBEEF;
        @(negedge clk); chk("t3_not_yet", bus.memory_write, 0);
        step();
        @(negedge clk);
        chk("t3_write", bus.memory_write, 1);
        chk("t3_done", bus.d_wr_done, 1);
        chk("t3_addr", bus.memory_address, 16'h1234);
        chk("t3_wdata", bus.memory_wdata, 16'hBEEF);
        step();
        bus.d_wr = 0;
        @(negedge clk); chk("t3_idle", state_dbg, ARB_IDLE);

        // write pending during an I fill
        step();
        bus.i_req = 1; bus.i_addr = 16'h0100;
        step();
        bus.d_wr = 1; bus.d_addr = 16'h3000; bus.d_wdata = 16'h5A5A; bus.memory_data_valid = 1;
        @(negedge clk); chk("t4_i_dv", bus.i_data_valid, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("t4_no_d_dv", bus.d_data_valid, 0);
            chk("t4_no_write", bus.memory_write, 0);
        end
        step();
        bus.i_req = 0; bus.memory_data_valid = 0;
        @(negedge clk); chk("t4_drop_no_write", bus.memory_write, 0);
        step();
        @(negedge clk); chk("t4_bubble_no_write", bus.memory_write, 0);
        step();
        @(negedge clk);
        chk("t4_write", bus.memory_write, 1);
        chk("t4_addr", bus.memory_address, 16'h3000);
        step();
        bus.d_wr = 0;

        // async reset in the middle of a D fill
        step();
        bus.d_req = 1; bus.d_addr = 16'h0800;
        step();
        @(negedge clk); chk("t5_d_grant", bus.d_grant, 1);
        step();
        bus.memory_data_valid = 1;
        #2;
        rst_n = 1'b0; bus.d_req = 0;
        #1;
        chk("t5_rst_grant", bus.d_grant, 0);
        chk("t5_rst_en", bus.memory_enable, 0);
        chk("t5_rst_addr", bus.memory_address, 0);
        chk("t5_rst_dv", bus.d_data_valid, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1; bus.memory_data_valid = 0; bus.d_req = 1;
        step();
        @(negedge clk); chk("t5_restart_grant", bus.d_grant, 1);
        step();
        bus.d_req = 0;
        repeat (2) step();

        // stray valid while idle
        bus.memory_data_valid = 1;
        @(negedge clk);
        chk("t6_i_dv", bus.i_data_valid, 0);
        chk("t6_d_dv", bus.d_data_valid, 0);
        step();
        bus.memory_data_valid = 0;

        // random traffic
        done_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 3) == 0) bus.i_req = ~bus.i_req;
            if ($urandom_range(0, 3) == 0) bus.d_req = ~bus.d_req;
            if (bus.d_wr && done_seen) bus.d_wr = 0;
            else if (!bus.d_wr && $urandom_range(0, 7) == 0) begin
                bus.d_wr = 1; bus.d_wdata = 16'($urandom);
            end
            bus.i_addr = 16'($urandom);
            bus.d_addr = 16'($urandom);
            bus.memory_data_valid = $urandom_range(0, 1) == 1;
            @(negedge clk);
            done_seen = bus.d_wr_done;
        end
        step();
        idle_inputs();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-cache and data-cache controllers. Each cache controller's fill FSM raises a request while it is busy. A request can be a block fill, or a single-word write-through for the D-cache. The arbiter grants one owner at a time, muxes that owner's address, write and data onto memory, and returns `memory_data_valid` only to the owner. It sits between the two cache controllers and the memory model.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data word width

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  I-cache fill request; held high for the whole fill
- `i_addr`  in  ADDR_W  I-cache fill address, updated by its fill FSM
- `d_req`  in  1  D-cache fill request; held high for the whole fill
- `d_addr`  in  ADDR_W  D-cache address, used for fills and writes
- `d_wr`  in  1  D-cache write-through request; held until `d_wr_done`
- `d_wdata`  in  DATA_W  write-through data
- `i_grant`  out  1  I-cache currently owns memory
- `d_grant`  out  1  D-cache currently owns memory, for fill or write
- `i_data_valid`  out  1  `memory_data_valid` routed to the I-cache
- `d_data_valid`  out  1  `memory_data_valid` routed to the D-cache
- `d_wr_done`  out  1  one-cycle pulse: write-through issued
- `memory_enable`  out  1  memory access this cycle
- `memory_write`  out  1  memory write this cycle
- `memory_address`  out  ADDR_W  address to memory
- `memory_wdata`  out  DATA_W  write data to memory
- `memory_data_valid`  in  1  memory read data valid

## Operation
- FSM states: `IDLE`, `I_FILL`, `D_FILL`, `D_WRITE`. Use a 2-bit encoding.
- Transitions out of `IDLE`:
  - only `i_req` high: go to `I_FILL`
  - only `d_req` or only `d_wr` high: go to `D_FILL` or `D_WRITE` respectively
  - `d_req` and `d_wr` both high: `D_FILL` first; `d_wr` stays pending
  - I and D requests both pending: tie-break (see Configuration)
- `I_FILL` / `D_FILL`:
  - stay while the owner's req is high
  - go to `IDLE` on the first cycle that req is low
  - no direct fill-to-fill hand-off
- `D_WRITE`:
  - lasts exactly 1 cycle
  - `memory_write`=1 and `d_wr_done`=1 in that cycle
  - next state is `IDLE`
- Output mux:
  - in a fill state: `memory_address` = owner's addr, `memory_enable` = owner's req, `memory_write` = 0
  - in `IDLE`: all memory outputs 0
- `memory_data_valid` AND `I_FILL` gives `i_data_valid`; AND `D_FILL` gives `d_data_valid`. Valid arriving in `IDLE` or `D_WRITE` is dropped.
- A requester dropping req before being granted withdraws the request; no error is flagged.
- A request asserted while the other side owns memory waits. Wait time is unbounded only under fixed priority.

## Timing
- Reset: state = `IDLE`, `last_owner` = I. All outputs are 0 while `rst_n` is low.
- Reset mid-fill: abort immediately. Memory outputs are 0 from the reset assertion on. The caches are reset by the same `rst_n`.
- State is registered; grants and memory outputs decode combinationally from the state.
- Request high in cycle n while in `IDLE` gives grant in cycle n+1. `memory_enable` is high the same cycle as the grant.
- Fill release: req low in cycle m gives `IDLE` in m+1. The earliest new grant is m+2 (one bubble cycle).
- Requesters must keep req high until their last `memory_data_valid` has been received. The arbiter does not track in-flight memory reads.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - a tie in `IDLE` goes to the side not in `last_owner`
  - `last_owner` updates on every grant
  - first tie after reset goes to D
- Undefined: fixed priority, D always wins a tie. `last_owner` is not implemented.

## Structure
- Shared package/include holds:
  - state encodings `ARB_IDLE`/`ARB_I_FILL`/`ARB_D_FILL`/`ARB_D_WRITE`
  - owner encodings `OWN_I`/`OWN_D`
  - default widths
- One sub-module: `mem_arb_pick`, the combinational tie-break. Inputs: `i_pend`, `d_fill_pend`, `d_wr_pend`, `last_owner`. Output: next state. Keeping it separate isolates the `MEM_ARB_RR_EN` logic.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- Reset, then `i_req`=1 with `i_addr`=0x0040 in cycle 1: `i_grant`=1 in cycle 2, `memory_address`=0x0040. 8 valids are routed to `i_data_valid` only. `i_req` low gives `IDLE` the next cycle.
- `i_req` and `d_req` rise the same cycle after reset: `d_grant` first. After D releases, one bubble cycle, then `i_grant`. With `MEM_ARB_RR_EN`, the next tie goes to I.
- `d_wr`=1, `d_addr`=0x1234, `d_wdata`=0xBEEF: one cycle with `memory_write`=1 and `d_wr_done`=1 at that address and data, then `IDLE`.
- `d_wr` asserted during an `I_FILL`: no write until `i_req` drops. The write then issues 2 cycles after the drop, and `i_data_valid` is never seen by the D side.
- `rst_n` pulsed low mid-`D_FILL`: all outputs 0 asynchronously. Restart is in `IDLE` and a fresh request is granted normally.
- Stray `memory_data_valid` in `IDLE`: both `*_data_valid` outputs stay 0.
